// File: rtl/lvds_link_pkg.sv
// lvds_link_pkg: shared definitions for the LVDS TX link slice.
//   arb_state_t  - arbiter state encoding (S_DOWN / S_IDLE / S_BURST)
//   VALID_BIT    - bit position of the word-valid flag in a TX word
//   HB_IDLE_MAX  - idle-cycle count that triggers a heartbeat word
//   pw_from_chw  - payload width left in a 32-bit word after valid + channel ID
package lvds_link_pkg;

    typedef enum logic [1:0] {
        S_DOWN  = 2'd0,
        S_IDLE  = 2'd1,
        S_BURST = 2'd2
    } arb_state_t;

    localparam int unsigned VALID_BIT   = 31;
    localparam logic [15:0] HB_IDLE_MAX = 16'hFFFF;

    function automatic int unsigned pw_from_chw(input int unsigned ch_w);
        return 31 - ch_w;
    endfunction

endpackage

// File: rtl/lvds_rr_pick.sv
// lvds_rr_pick: combinational round-robin pick.
// Scans req_valid starting at last_grant+1, wrapping at NREQ.
//   req_valid  in  NREQ  request vector
//   last_grant in  CH_W  most recently served channel
//   any        out 1     at least one request is valid
//   winner     out CH_W  first valid index after last_grant
module lvds_rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned CH_W = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [CH_W-1:0] last_grant,
    output logic            any,
    output logic [CH_W-1:0] winner
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [31:0] idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = (32'(last_grant) + off) % NREQ;
            if (!any && req_valid[idx[IW-1:0]]) begin
                any    = 1'b1;
                winner = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/lvds_tx_arbiter.sv
// lvds_tx_arbiter: round-robin arbiter sharing the LVDS TX word FIFO
// between NREQ requesters. Accepted payloads are tagged
// {valid, channel ID, payload} and held in a one-entry output register
// that drains into the FIFO write port.
//
// Ports:
//   tx_inclock  in   clock
//   reset_n     in   synchronous active-low reset
//   link_up     in   link aligned; no grants while low
//   req_valid   in   NREQ      per-requester valid
//   req_data    in   NREQ*PW   requester i payload at [i*PW +: PW]
//   req_ready   out  NREQ      per-requester ready
//   d_in_tx     out  32        word to TX FIFO
//   enq_tx      out            TX FIFO enqueue strobe
//   full_n_tx   in             TX FIFO not full
//   grant_id    out  CH_W      current/last granted channel
//   busy        out            burst in progress or output word pending
//
// Optional feature: define LVDS_TX_ARB_HEARTBEAT_EN to emit a heartbeat
// word on channel all-ones after HB_IDLE_MAX idle cycles.
module lvds_tx_arbiter
    import lvds_link_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned PW        = pw_from_chw(CH_W)
) (
    input  logic                 tx_inclock,
    input  logic                 reset_n,
    input  logic                 link_up,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*PW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          d_in_tx,
    output logic                 enq_tx,
    input  logic                 full_n_tx,
    output logic [CH_W-1:0]      grant_id,
    output logic                 busy
);

    localparam int unsigned     BC_W       = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

    arb_state_t       state, state_nxt;
    logic [CH_W-1:0]  last_grant;
    logic [BC_W-1:0]  burst_cnt;
    logic             out_valid;
    logic [31:0]      out_data;

    logic             pick_any;
    logic [CH_W-1:0]  pick_winner;

    logic             can_take;
    logic             cur_valid;
    logic [PW-1:0]    cur_data;
    logic             hs;
    logic             burst_end;
    logic             arb_take;
    logic             load;
    logic [31:0]      load_data;

    logic             hb_fire;
    logic [PW-1:0]    hb_seq;

    lvds_rr_pick #(
        .NREQ (NREQ),
        .CH_W (CH_W)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .winner     (pick_winner)
    );

`ifdef LVDS_TX_ARB_HEARTBEAT_EN
    logic [15:0] idle_cnt;

    assign hb_fire = (state == S_IDLE) && link_up && !(|req_valid) &&
                     (idle_cnt == HB_IDLE_MAX) && !out_valid;

    // Counter saturates at HB_IDLE_MAX while the output register is busy,
    // so the heartbeat goes out as soon as the register frees up.
    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            idle_cnt <= '0;
            hb_seq   <= '0;
        end else if (|req_valid) begin
            idle_cnt <= '0;
        end else if (hb_fire) begin
            idle_cnt <= '0;
            hb_seq   <= hb_seq + 1'b1;
        end else if ((state == S_IDLE) && (idle_cnt != HB_IDLE_MAX)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign hb_fire = 1'b0;
    assign hb_seq  = '0;
`endif

    assign d_in_tx = out_data;
    assign enq_tx  = out_valid & full_n_tx;
    assign busy    = (state == S_BURST) | out_valid;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        hs        = 1'b0;
        burst_end = 1'b0;
        arb_take  = 1'b0;
        load      = 1'b0;
        load_data = out_data;
        can_take  = ~out_valid | full_n_tx;
        cur_valid = 1'b0;
        cur_data  = '0;

        for (int unsigned i = 0; i < NREQ; i++) begin
            if (CH_W'(i) == grant_id) begin
                cur_valid = req_valid[i];
                cur_data  = req_data[i*PW +: PW];
            end
        end

        case (state)
            S_DOWN: begin
                if (link_up) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!link_up) begin
                    state_nxt = S_DOWN;
                end else if (pick_any) begin
                    arb_take  = 1'b1;
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                // Ready is gated by link_up in the same cycle so no word is
                // accepted once the link has dropped.
                if (!link_up) begin
                    state_nxt = S_DOWN;
                end else begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (CH_W'(i) == grant_id) req_ready[i] = can_take;
                    end
                    if (can_take) begin
                        if (cur_valid) begin
                            hs        = 1'b1;
                            load      = 1'b1;
                            load_data = '0;
                            load_data[VALID_BIT]              = 1'b1;
                            load_data[VALID_BIT-1 -: CH_W]    = grant_id;
                            load_data[PW-1:0]                 = cur_data;
                            burst_end = (burst_cnt == BURST_LAST);
                        end else begin
                            burst_end = 1'b1;
                        end
                        if (burst_end) state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_DOWN;
        endcase

        if (hb_fire) begin
            load      = 1'b1;
            load_data = '0;
            load_data[VALID_BIT]           = 1'b1;
            load_data[VALID_BIT-1 -: CH_W] = '1;
            load_data[PW-1:0]              = hb_seq;
        end
    end

    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            state      <= S_DOWN;
            grant_id   <= '0;
            last_grant <= CH_W'(NREQ - 1);
            burst_cnt  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state <= state_nxt;
            if (arb_take) begin
                grant_id  <= pick_winner;
                burst_cnt <= '0;
            end
            if (hs) burst_cnt <= burst_cnt + 1'b1;
            if (burst_end) last_grant <= grant_id;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (enq_tx) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
